// File: rtl/pe_mac_os.sv
// pe_mac_os: output-stationary multiply-accumulate processing element.
// Accumulates din*win over first/last framed windows, forwards operands and
// framing to neighbours with one cycle of latency, and reports each window
// result with its term count, an overflow flag and a sticky protocol error.
module pe_mac_os #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned SIGNED   = 0,
  parameter int unsigned SATURATE = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] win,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  output logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] wout,
  output logic              out_valid_fwd,
  output logic              out_first_fwd,
  output logic              out_last_fwd,
  output logic [ACC_W-1:0]  out,
  output logic              out_valid,
  output logic              out_sat,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              err
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned EXT_W  = SUM_W - PROD_W;

  typedef enum logic {IDLE, ACC} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              win_sat;

  logic [PROD_W-1:0] din_x;
  logic [PROD_W-1:0] win_x;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  prod_ext;
  logic [SUM_W-1:0]  base_ext;
  logic [SUM_W-1:0]  sum;
  logic              ovf;
  logic [ACC_W-1:0]  clamp;
  logic [ACC_W-1:0]  sum_res;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              sat_nxt;

  logic              load;
  logic              capture;
  logic              set_err;

  // Product and sum datapath; extension mode follows the operand signedness
  always_comb begin
    if (SIGNED != 0) begin
      din_x    = {{DATA_W{din[DATA_W-1]}}, din};
      win_x    = {{DATA_W{win[DATA_W-1]}}, win};
    end else begin
      din_x    = {{DATA_W{1'b0}}, din};
      win_x    = {{DATA_W{1'b0}}, win};
    end
    prod = din_x * win_x;

    if (SIGNED != 0) begin
      prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};
      base_ext = in_first ? '0 : {acc[ACC_W-1], acc};
    end else begin
      prod_ext = {{EXT_W{1'b0}}, prod};
      base_ext = in_first ? '0 : {1'b0, acc};
    end
    sum = base_ext + prod_ext;

    if (SIGNED != 0) begin
      ovf   = sum[ACC_W] ^ sum[ACC_W-1];
      clamp = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      ovf   = sum[ACC_W];
      clamp = {ACC_W{1'b1}};
    end

    if ((SATURATE != 0) && ovf) sum_res = clamp;
    else                        sum_res = sum[ACC_W-1:0];
  end

  // Window term count and overflow flag including the current beat
  always_comb begin
    if (in_first)  cnt_nxt = CNT_W'(1);
    else if (&cnt) cnt_nxt = cnt;
    else           cnt_nxt = cnt + CNT_W'(1);
    sat_nxt = (in_first ? 1'b0 : win_sat) | ovf;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and beat-handling decode
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    capture   = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!in_first) begin
            set_err = 1'b1;
          end else if (in_last) begin
            capture = 1'b1;
          end else begin
            load      = 1'b1;
            state_nxt = ACC;
          end
        end
      end
      ACC: begin
        if (in_valid) begin
          if (in_first) set_err = 1'b1;
          if (in_last) begin
            capture   = 1'b1;
            state_nxt = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, window count and window overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      win_sat <= 1'b0;
    end else if (load) begin
      acc     <= sum_res;
      cnt     <= cnt_nxt;
      win_sat <= sat_nxt;
    end
  end

  // Result registers and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      out_sat   <= 1'b0;
      term_cnt  <= '0;
      err       <= 1'b0;
    end else begin
      out_valid <= capture;
      err       <= err | set_err;
      if (capture) begin
        out      <= sum_res;
        out_sat  <= sat_nxt;
        term_cnt <= cnt_nxt;
      end
    end
  end

  // Neighbour forwarding: operands held between valid beats, flags every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout          <= '0;
      wout          <= '0;
      out_valid_fwd <= 1'b0;
      out_first_fwd <= 1'b0;
      out_last_fwd  <= 1'b0;
    end else begin
      out_valid_fwd <= in_valid;
      out_first_fwd <= in_valid & in_first;
      out_last_fwd  <= in_valid & in_last;
      if (in_valid) begin
        dout <= din;
        wout <= win;
      end
    end
  end

endmodule
